// File: rtl/newhope_pkg.sv
// Shared constants and types for the NewHope polynomial datapath.
// Used by the coefficient-RAM arbiter and its round-robin picker.
package newhope_pkg;

   localparam int POLY_ADDR_W = 9;
   localparam int POLY_DATA_W = 16;
   localparam int N_COEFF     = 512;

   localparam int CL_DECODER  = 0;
   localparam int CL_NTT      = 1;
   localparam int CL_ENCODER  = 2;

   localparam int OWNER_W     = 3;

   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_GRANT = 2'd1,
      ARB_TURN  = 2'd2
   } arb_state_e;

   // Next round-robin start position after the given owner.
   function automatic logic [OWNER_W-1:0] rr_next(
      input logic [OWNER_W-1:0] idx,
      input int                 n
   );
      if (int'(idx) >= n - 1) begin
         return '0;
      end
      return idx + 1'b1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or
// after ptr_i (wrapping), returned as one-hot and as index.
module rr_pick
   import newhope_pkg::*;
#(
   parameter int N  = 3,
   parameter int IW = OWNER_W
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          any_o
);

   logic found;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         for (int k = 0; k < N; k++) begin
            if (!found && req_i[k] &&
                k == (int'(ptr_i) + i) % N) begin
               found    = 1'b1;
               gnt_o[k] = 1'b1;
               idx_o    = IW'(k);
            end
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/poly_ram_arbiter.sv
// Round-robin owner of the coefficient RAM's port A, with burst
// ownership, a one-cycle turnaround and a sticky misuse flag.
module poly_ram_arbiter
   import newhope_pkg::*;
#(
   parameter int NUM_CLIENTS = 3,
   parameter int ADDR_W      = POLY_ADDR_W,
   parameter int DATA_W      = POLY_DATA_W
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CLIENTS-1:0]        cl_req,
   output logic [NUM_CLIENTS-1:0]        cl_gnt,
   input  logic [NUM_CLIENTS-1:0]        cl_we,
   input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
   input  logic [NUM_CLIENTS*DATA_W-1:0] cl_di,
   output logic [DATA_W-1:0]             cl_do,
   output logic                          ram_we,
   output logic [ADDR_W-1:0]             ram_addr,
   output logic [DATA_W-1:0]             ram_di,
   input  logic [DATA_W-1:0]             ram_do,
   output logic                          busy,
   output logic [OWNER_W-1:0]            owner,
   output logic                          viol
);

   localparam int NC = NUM_CLIENTS;

   arb_state_e         state_q, state_d;
   logic [NC-1:0]      gnt_q, gnt_d;
   logic [OWNER_W-1:0] owner_q, owner_d;
   logic [OWNER_W-1:0] rr_q, rr_d;
   logic               viol_q, viol_d;

   logic [NC-1:0]      pick_gnt;
   logic [OWNER_W-1:0] pick_idx;
   logic               pick_any;
   logic               own_req;
   logic               bad_we;

   rr_pick #(
      .N  (NC),
      .IW (OWNER_W)
   ) u_pick (
      .req_i (cl_req),
      .ptr_i (rr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .any_o (pick_any)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARB_IDLE;
         gnt_q   <= '0;
         owner_q <= '0;
         rr_q    <= '0;
         viol_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         rr_q    <= rr_d;
         viol_q  <= viol_d;
      end
   end

   always_comb begin
      own_req = 1'b0;
      for (int k = 0; k < NC; k++) begin
         if (owner_q == OWNER_W'(k)) begin
            own_req = cl_req[k];
         end
      end
   end

   // A write is legal only from the current grantee while granted.
   assign bad_we = |(cl_we & ~(gnt_q & {NC{state_q == ARB_GRANT}}));

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      owner_d = owner_q;
      rr_d    = rr_q;
      viol_d  = viol_q | bad_we;
      case (state_q)
         ARB_IDLE: begin
            if (pick_any) begin
               state_d = ARB_GRANT;
               gnt_d   = pick_gnt;
               owner_d = pick_idx;
            end
         end
         ARB_GRANT: begin
            if (!own_req) begin
               state_d = ARB_TURN;
               gnt_d   = '0;
               rr_d    = rr_next(owner_q, NC);
            end
         end
         ARB_TURN: begin
            state_d = ARB_IDLE;
            if (pick_any) begin
               state_d = ARB_GRANT;
               gnt_d   = pick_gnt;
               owner_d = pick_idx;
            end
         end
         default: begin
            state_d = ARB_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      ram_we   = 1'b0;
      ram_addr = '0;
      ram_di   = '0;
      if (state_q == ARB_GRANT) begin
         for (int k = 0; k < NC; k++) begin
            if (owner_q == OWNER_W'(k)) begin
               ram_we   = cl_we[k];
               ram_addr = cl_addr[k*ADDR_W +: ADDR_W];
               ram_di   = cl_di[k*DATA_W +: DATA_W];
            end
         end
      end
   end

   assign cl_gnt = gnt_q;
   assign owner  = owner_q;
   assign busy   = (state_q != ARB_IDLE);
   assign viol   = viol_q;
   assign cl_do  = ram_do;

endmodule

// File: tb/tb_poly_ram_arbiter.sv
// Directed bench for poly_ram_arbiter with a behavioural
// 512x16 RAM on port A and queued expected grants/read data.
module tb_poly_ram_arbiter;

   localparam int NC = 3;
   localparam int AW = 9;
   localparam int DW = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic [NC-1:0]    cl_req;
   logic [NC-1:0]    cl_gnt;
   logic [NC-1:0]    cl_we;
   logic [NC*AW-1:0] cl_addr;
   logic [NC*DW-1:0] cl_di;
   logic [DW-1:0]    cl_do;
   logic             ram_we;
   logic [AW-1:0]    ram_addr;
   logic [DW-1:0]    ram_di;
   logic [DW-1:0]    ram_do;
   logic             busy;
   logic [2:0]       owner;
   logic             viol;

   int vectors     = 0;
   int miscompares = 0;

   logic [DW-1:0] rd_exp_q[$];
   int            own_exp_q[$];
   logic [DW-1:0] mem [0:511];

   poly_ram_arbiter #(
      .NUM_CLIENTS (NC),
      .ADDR_W      (AW),
      .DATA_W      (DW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cl_req   (cl_req),
      .cl_gnt   (cl_gnt),
      .cl_we    (cl_we),
      .cl_addr  (cl_addr),
      .cl_di    (cl_di),
      .cl_do    (cl_do),
      .ram_we   (ram_we),
      .ram_addr (ram_addr),
      .ram_di   (ram_di),
      .ram_do   (ram_do),
      .busy     (busy),
      .owner    (owner),
      .viol     (viol)
   );

   always #5 clk = ~clk;

   // RAM model: 1-cycle read latency, preloaded while in reset.
   always @(posedge clk) begin
      if (rst) mem[511] <= 16'h0D00;
      else if (ram_we) mem[ram_addr] <= ram_di;
      ram_do <= mem[ram_addr];
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int k;
      int bad;

      rst = 1'b1;
      cl_req = '0;
      cl_we = '0;
      cl_addr = '0;
      cl_di = '0;
      #1;
      chk("rst_gnt", cl_gnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_viol", viol, 0);
      chk("rst_owner", owner, 0);
      chk("rst_we", ram_we, 0);
      chk("rst_addr", ram_addr, 0);
      chk("rst_di", ram_di, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // single client write
      cl_req = 3'b001;
      tick;
      chk("w_gnt", cl_gnt, 3'b001);
      chk("w_busy", busy, 1);
      cl_we = 3'b001;
      cl_addr[0 +: AW] = 9'd5;
      cl_di[0 +: DW] = 16'h1ABC;
      #1;
      chk("w_we", ram_we, 1);
      chk("w_addr", ram_addr, 9'd5);
      chk("w_di", ram_di, 16'h1ABC);
      tick;
      cl_we = '0;
      cl_req = '0;
      tick;
      chk("w_turn_gnt", cl_gnt, 0);
      chk("w_turn_busy", busy, 1);
      chk("w_turn_addr", ram_addr, 0);
      tick;
      chk("w_idle_busy", busy, 0);

      // round robin from reset
      rst = 1'b1;
      #1;
      rst = 1'b0;
      chk("rr_rst_gnt", cl_gnt, 0);
      own_exp_q.push_back(0);
      own_exp_q.push_back(1);
      own_exp_q.push_back(2);
      own_exp_q.push_back(0);
      cl_req = 3'b111;
      for (int n = 0; n < 4; n++) begin
         k = own_exp_q.pop_front();
         tick;
         chk("rr_gnt", cl_gnt, 1 << k);
         chk("rr_owner", owner, k);
         for (int c = 0; c < 3; c++) begin
            tick;
            chk("rr_hold", cl_gnt, 1 << k);
         end
         cl_req[k] = 1'b0;
         tick;
         chk("rr_gap", cl_gnt, 0);
         chk("rr_gap_busy", busy, 1);
         if (n < 3) cl_req[k] = 1'b1;
         else cl_req = '0;
      end
      tick;
      chk("rr_idle", busy, 0);

      // no preemption over a long burst
      cl_req = 3'b010;
      tick;
      chk("np_gnt1", cl_gnt, 3'b010);
      cl_req = 3'b110;
      bad = 0;
      repeat (512) begin
         tick;
         if (cl_gnt !== 3'b010) bad++;
      end
      chk("np_held", bad, 0);
      cl_req = 3'b100;
      tick;
      chk("np_turn", cl_gnt, 0);
      tick;
      chk("np_gnt2", cl_gnt, 3'b100);
      chk("np_owner2", owner, 2);
      cl_req = '0;
      tick;
      tick;
      chk("np_idle", busy, 0);

      // write without grant
      cl_we = 3'b100;
      cl_addr[2*AW +: AW] = 9'h033;
      cl_di[2*DW +: DW] = 16'hBEEF;
      #1;
      chk("v_we", ram_we, 0);
      chk("v_addr", ram_addr, 0);
      tick;
      chk("v_set", viol, 1);
      cl_we = '0;
      repeat (3) tick;
      chk("v_sticky", viol, 1);

      // async reset mid-burst
      cl_req = 3'b001;
      tick;
      chk("r_gnt", cl_gnt, 3'b001);
      cl_we = 3'b001;
      cl_addr[0 +: AW] = 9'h007;
      cl_di[0 +: DW] = 16'h0123;
      #1;
      chk("r_we", ram_we, 1);
      #2;
      rst = 1'b1;
      #1;
      chk("r_async_gnt", cl_gnt, 0);
      chk("r_async_we", ram_we, 0);
      chk("r_async_busy", busy, 0);
      chk("r_viol_clr", viol, 0);
      rst = 1'b0;
      cl_we = '0;
      cl_req = 3'b111;
      tick;
      chk("r_prio_gnt", cl_gnt, 3'b001);
      chk("r_prio_owner", owner, 0);
      cl_req = '0;
      tick;
      tick;

      // read path
      cl_req = 3'b010;
      tick;
      chk("rd_gnt", cl_gnt, 3'b010);
      cl_addr[AW +: AW] = 9'h1FF;
      rd_exp_q.push_back(16'h0D00);
      #1;
      chk("rd_addr", ram_addr, 9'h1FF);
      tick;
      chk("rd_1ff", cl_do, rd_exp_q.pop_front());
      cl_addr[AW +: AW] = 9'd5;
      rd_exp_q.push_back(16'h1ABC);
      tick;
      chk("rd_5", cl_do, rd_exp_q.pop_front());
      cl_req = '0;
      tick;
      tick;
      chk("end_idle", busy, 0);
      chk("end_viol", viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
